// File: rtl/signed_frame_accumulator.sv
// Accumulates frames of N signed samples with add-and-detect-overflow steps,
// then presents the (wrapped or saturated) sum with a sticky overflow flag.
module signed_frame_accumulator #(
  parameter int W        = 4,
  parameter int N        = 4,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_overflow
);

  localparam int          CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {ACC, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   acc_reg;
  logic [CW-1:0]  count_reg;
  logic           sticky_reg;
  logic           out_valid_reg;
  logic [W-1:0]   out_sum_reg;
  logic           out_overflow_reg;

  logic           accept;
  logic           last;
  logic [W-1:0]   sum_raw;
  logic [W-1:0]   sum_step;
  logic           ovf;

  assign in_ready = (state_reg == ACC);
  assign accept   = in_valid && in_ready;
  assign last     = (count_reg == LAST);
  assign sum_raw  = acc_reg + in_data;

  // Overflow only when both operands share a sign and the result flips it.
  assign ovf = (acc_reg[W-1] == in_data[W-1]) && (sum_raw[W-1] != acc_reg[W-1]);

  always_comb begin
    sum_step = sum_raw;
    if ((SATURATE != 0) && ovf) begin
      sum_step = acc_reg[W-1] ? MAX_NEG : MAX_POS;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACC:     if (accept && last) state_next = DONE;
      DONE:    if (out_ready)      state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ACC;
      acc_reg          <= '0;
      count_reg        <= '0;
      sticky_reg       <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_sum_reg      <= '0;
      out_overflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next == DONE);
      if (accept) begin
        if (last) begin
          // Frame closes: publish the result and start the next frame clean.
          out_sum_reg      <= sum_step;
          out_overflow_reg <= sticky_reg | ovf;
          acc_reg          <= '0;
          count_reg        <= '0;
          sticky_reg       <= 1'b0;
        end else begin
          acc_reg    <= sum_step;
          count_reg  <= count_reg + CW'(1);
          sticky_reg <= sticky_reg | ovf;
        end
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_sum      = out_sum_reg;
  assign out_overflow = out_overflow_reg;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Bench for signed_frame_accumulator: wrap and saturate instances share stimulus,
// plus an N=1 instance; results checked against a table and an arithmetic model.
module tb_signed_frame_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_overflow0;
  logic [3:0] out_sum0;
  logic       in_ready1, out_valid1, out_overflow1;
  logic [3:0] out_sum1;

  logic       v2, r2;
  logic [3:0] d2;
  logic       in_ready2, out_valid2, out_overflow2;
  logic [3:0] out_sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_frame_accumulator #(.W(4), .N(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_overflow(out_overflow0));

  signed_frame_accumulator #(.W(4), .N(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_overflow(out_overflow1));

  signed_frame_accumulator #(.W(4), .N(1), .SATURATE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2),
    .in_data(d2), .out_valid(out_valid2), .out_ready(r2),
    .out_sum(out_sum2), .out_overflow(out_overflow2));

  typedef struct {
    int s[4];
    int sum0;
    int ovf0;
    int sum1;
    int ovf1;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer sum per step, range-checked against [-8,7].
  function automatic void model(input int s[4], input bit sat, output int sum, output int ovf);
    int run;
    run = 0;
    ovf = 0;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = run + s[i];
      if (t > 7 || t < -8) begin
        ovf = 1;
        if (sat) t = (t > 7) ? 7 : -8;
        else     t = (t > 7) ? t - 16 : t + 16;
      end
      run = t;
    end
    sum = run;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int s[4], input int max_gap);
    for (int i = 0; i < 4; i++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        tick();
      end
      chk("in_ready_acc", int'(in_ready0), 1);
      in_valid = 1'b1;
      in_data  = 4'(s[i]);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string nm, input int sum0, input int ovf0,
                              input int sum1, input int ovf1, input int hold);
    chk({nm, " out_valid0"}, int'(out_valid0), 1);
    chk({nm, " out_valid1"}, int'(out_valid1), 1);
    chk({nm, " sum_wrap"}, int'($signed(out_sum0)), sum0);
    chk({nm, " ovf_wrap"}, int'(out_overflow0), ovf0);
    chk({nm, " sum_sat"}, int'($signed(out_sum1)), sum1);
    chk({nm, " ovf_sat"}, int'(out_overflow1), ovf1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      tick();
      chk({nm, " hold_in_ready"}, int'(in_ready0), 0);
      chk({nm, " hold_sum"}, int'($signed(out_sum0)), sum0);
      chk({nm, " hold_valid"}, int'(out_valid1), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " release_valid"}, int'(out_valid0), 0);
    chk({nm, " release_in_ready"}, int'(in_ready0 & in_ready1), 1);
  endtask

  initial begin
    int s[4];
    int es0, eo0, es1, eo1;

    vecs[0] = '{s: '{1, 2, 3, 1},    sum0: 7,  ovf0: 0, sum1: 7,  ovf1: 0};
    vecs[1] = '{s: '{7, 1, -1, 0},   sum0: 7,  ovf0: 1, sum1: 6,  ovf1: 1};
    vecs[2] = '{s: '{-8, -1, 0, 0},  sum0: 7,  ovf0: 1, sum1: -8, ovf1: 1};
    vecs[3] = '{s: '{7, 1, 0, 0},    sum0: -8, ovf0: 1, sum1: 7,  ovf1: 1};
    vecs[4] = '{s: '{1, 2, 3, 1},    sum0: 7,  ovf0: 0, sum1: 7,  ovf1: 0};
    vecs[5] = '{s: '{4, 4, -4, -4},  sum0: 0,  ovf0: 1, sum1: -1, ovf1: 1};
    vecs[6] = '{s: '{-3, -3, 2, 1},  sum0: -3, ovf0: 0, sum1: -3, ovf1: 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    v2 = 1'b0; d2 = '0; r2 = 1'b0;
    tick(); tick();
    chk("reset out_valid", int'(out_valid0 | out_valid1), 0);
    chk("reset out_sum", int'(out_sum0), 0);
    chk("reset out_overflow", int'(out_overflow0), 0);
    chk("reset in_ready", int'(in_ready0), 1);
    rst_n = 1'b1;
    tick();

    // Table vectors, back-to-back with continuous in_valid.
    for (int v = 0; v < 7; v++) begin
      feed(vecs[v].s, 0);
      check_result($sformatf("vec%0d", v), vecs[v].sum0, vecs[v].ovf0,
                   vecs[v].sum1, vecs[v].ovf1, 0);
    end

    // Gapped input, then 3 cycles of backpressure with in_valid held high.
    s = '{1, 1, 1, 1};
    feed(s, 0);
    chk("no_early_valid", int'(out_valid0), 1);
    check_result("backpressure", 4, 0, 4, 0, 3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      tick();
      chk("gap_no_valid", int'(out_valid0), 0);
      in_valid = 1'b1;
      in_data  = 4'd1;
      tick();
      in_valid = 1'b0;
    end
    check_result("gapped", 4, 0, 4, 0, 0);

    // Reset in the middle of a frame, between clock edges.
    in_valid = 1'b1; in_data = 4'd5; tick(); tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_rst out_valid", int'(out_valid0), 0);
    chk("midframe_rst in_ready", int'(in_ready0), 1);
    #1 rst_n = 1'b1;
    tick();
    s = '{1, 1, 1, 1};
    feed(s, 0);
    check_result("after_rst", 4, 0, 4, 0, 0);

    // Reset while holding a result.
    s = '{7, 1, 0, 0};
    feed(s, 0);
    chk("pre_done_rst valid", int'(out_valid0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("done_rst out_valid", int'(out_valid0), 0);
    chk("done_rst out_sum", int'(out_sum0), 0);
    chk("done_rst out_overflow", int'(out_overflow1), 0);
    chk("done_rst in_ready", int'(in_ready1), 1);
    #1 rst_n = 1'b1;
    tick();

    // Random frames with gaps and backpressure against the model.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(15, 0)) - 8;
      model(s, 1'b0, es0, eo0);
      model(s, 1'b1, es1, eo1);
      feed(s, 2);
      check_result($sformatf("rand%0d", f), es0, eo0, es1, eo1,
                   int'($urandom_range(2, 0)));
    end

    // N=1: every accepted sample is a frame with no overflow.
    r2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int x;
      x = (i == 0) ? 7 : (i == 1) ? -8 : int'($urandom_range(15, 0)) - 8;
      chk("n1 in_ready", int'(in_ready2), 1);
      v2 = 1'b1;
      d2 = 4'(x);
      tick();
      v2 = 1'b0;
      chk("n1 out_valid", int'(out_valid2), 1);
      chk("n1 out_sum", int'($signed(out_sum2)), x);
      chk("n1 out_overflow", int'(out_overflow2), 0);
      chk("n1 busy", int'(in_ready2), 0);
      tick();
      chk("n1 released", int'(out_valid2), 0);
    end
    r2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_frame_accumulator.md
Name: signed_frame_accumulator

Overview:
Sequential consumer stage that sits directly downstream of the 4-bit signed adder with overflow detection. It accumulates a frame of N two's-complement samples using the same add-and-detect-overflow rule. It then presents the frame result with a sticky per-frame overflow flag. Input and output use valid/ready handshakes, and the result can be either wrap-around or saturating.

Parameters:
W, 4, sample and accumulator width in bits (signed two's complement)
N, 4, samples per frame; legal range 1..2**16-1
SATURATE, 0, 0 = wrap-around sum (adder semantics); 1 = clamp to signed max/min on each overflowing step

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts a sample this cycle
in_data  input  W  signed sample
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_sum  output  W  signed frame sum (wrapped or saturated per SATURATE)
out_overflow  output  1  1 if any step in the frame overflowed

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous and active-low.
- State machine:
  - ACC: accepting samples.
  - DONE: holding the result.
- Reset (rst_n=0, asynchronous): state=ACC, acc=0, count=0, sticky=0, out_valid=0, out_sum=0, out_overflow=0.
- in_ready = (state==ACC). It is combinational from state only and never from in_valid.
- Accept = in_valid && in_ready. Cycles with in_valid=0 change nothing.
- Per accepted sample:
  - s = acc + in_data, truncated to W bits.
  - ovf = (acc[W-1]==in_data[W-1]) && (s[W-1]!=acc[W-1]).
  - If SATURATE=1 and ovf: s = acc[W-1] ? most-negative (1 followed by W-1 zeros) : most-positive (0 followed by W-1 ones).
  - If SATURATE=0, s is the wrapped value.
  - acc <= s, sticky <= sticky | ovf, count <= count+1.
- Frame end, when an accept occurs with count==N-1:
  - out_sum <= s.
  - out_overflow <= sticky | ovf.
  - out_valid <= 1 and state <= DONE.
  - acc, count and sticky are cleared to 0 in the same edge.
  - Latency: out_valid is high on the cycle after the Nth accepted sample.
- DONE:
  - in_ready=0.
  - out_sum and out_overflow are held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: out_valid <= 0, state <= ACC. A new frame can be accepted on the following cycle.
  - Minimum frame period is N+1 cycles. There is no overlap of frames.
- out_ready is ignored in ACC. in_valid is ignored in DONE, so no sample is lost or counted.
- N=1: every accepted sample completes a frame. out_sum = in_data and out_overflow = 0.
- Reset mid-frame or mid-DONE: the partial frame or pending result is discarded and every output returns to its reset value immediately.
- out_sum and out_overflow are registered. out_valid is registered.

Test Plan:
1. W=4, N=4, SATURATE=0; in_valid continuous with 1,2,3,1 -> out_valid one cycle after the 4th accept; out_sum=4'b0111 (7), out_overflow=0.
2. SATURATE=0; samples 7,1,-1,0.
   - Expected steps: 7+1=-8 (ovf), then -8+(-1)=7 (ovf), then 7.
   - Required: out_sum=4'b0111, out_overflow=1.
3. SATURATE=1; two frames.
   - 7,1,-1,0 -> steps 7 (clamped), 6, 6; out_sum=4'b0110, out_overflow=1.
   - -8,-1,0,0 -> out_sum=4'b1000, out_overflow=1.
4. Gaps and backpressure.
   - Samples 1,1,1,1 with in_valid low on alternate cycles -> out_sum=4, out_overflow=0, count advances only on accepts.
   - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable, no sample consumed.
   - Raise out_ready -> out_valid falls next cycle and in_ready rises.
5. Sticky clear between frames: frame 7,1,0,0 (out_overflow=1) followed by frame 1,2,3,1 -> second result out_sum=7, out_overflow=0.
6. Reset mid-frame: accept 5,5, pulse rst_n low between clock edges -> out_valid=0 and in_ready=1 immediately. Then 1,1,1,1 -> out_sum=4, out_overflow=0.
